// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock-tick divider.
// The high-phase threshold helper works on a fixed 16-bit width, so CNT_W must not exceed 16.
package clkdiv_pkg;

    localparam int LEGACY_VGA_DIV = 4;
    localparam int DIV_MIN        = 1;
    localparam int THR_W          = 16;

    // Counter values at or above this threshold drive the divided clock high.
    // As a result, the high phase is ceil(D/2) cycles long.
    function automatic logic [THR_W-1:0] high_threshold(input logic [THR_W-1:0] div);
        return div >> 1;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// A single divider channel. It holds the counter, the active divisor and the shadow divisor.
// It produces a registered one-cycle tick and a registered divided clock.
// A new divisor is staged in the shadow register. It becomes active only at the period
// boundary (wrap) or on sync, so a running period is never cut short or stretched.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = LEGACY_VGA_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    input  logic             sync,
    output logic             tick,
    output logic             div_clk
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic [CNT_W-1:0] div_eff;
    logic [CNT_W-1:0] cnt_inc;
    logic             wrap;
    logic             tick_q, tick_d;
    logic             div_clk_q, div_clk_d;

    // Next-state logic. A divisor of 0 counts as 1.
    // A write that lands on a wrap or sync cycle bypasses the shadow register.
    always_comb begin
        div_eff   = (act_q == '0) ? CNT_W'(DIV_MIN) : act_q;
        wrap      = en && (cnt_q == div_eff - CNT_W'(1));
        cnt_inc   = wrap ? '0 : cnt_q + CNT_W'(1);
        shd_d     = ld ? ld_val : shd_q;
        act_d     = (sync || wrap) ? shd_d : act_q;
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        div_clk_d = div_clk_q;
        if (sync) begin
            cnt_d     = '0;
            div_clk_d = 1'b0;
        end else if (en) begin
            cnt_d     = cnt_inc;
            tick_d    = wrap;
            div_clk_d = (THR_W'(cnt_inc) >= high_threshold(THR_W'(div_eff)));
        end
    end

    // State registers. Reset restores the default divisor and drops any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            act_q     <= CNT_W'(DEFAULT_DIV);
            shd_q     <= CNT_W'(DEFAULT_DIV);
            tick_q    <= 1'b0;
            div_clk_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            act_q     <= act_d;
            shd_q     <= shd_d;
            tick_q    <= tick_d;
            div_clk_q <= div_clk_d;
        end
    end

    assign tick    = tick_q;
    assign div_clk = div_clk_q;

endmodule

// File: rtl/clk_tick_divider.sv
// Top level of the multi-channel tick divider. All channels run from a single clock domain.
// The divisor-write channel select is decoded here, and out-of-range selects are ignored.
// When CLKDIV_SYNC_EN is defined, the sync_in port is added. It phase-aligns all channels
// and applies their pending divisors.
module clk_tick_divider
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 8,
    parameter int CH_W        = 1,
    parameter int DEFAULT_DIV = LEGACY_VGA_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] div_clk
`ifdef CLKDIV_SYNC_EN
    ,
    input  logic              sync_in
`endif
);

    logic [NUM_CH-1:0] ld_vec;
    logic              sync_w;

`ifdef CLKDIV_SYNC_EN
    assign sync_w = sync_in;
`else
    assign sync_w = 1'b0;
`endif

    // One-hot load strobes for each channel. A select that matches no channel loads nothing.
    always_comb begin
        ld_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ld_vec[i] = wr_en && (int'(wr_ch) == i);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_channel (
            .clk     (clk),
            .rst     (rst),
            .en      (ch_en[g]),
            .ld      (ld_vec[g]),
            .ld_val  (wr_div),
            .sync    (sync_w),
            .tick    (tick[g]),
            .div_clk (div_clk[g])
        );
    end

endmodule

// File: tb/tb_clk_tick_divider.sv
// Directed, self-checking bench for clk_tick_divider. It uses two channels, an 8-bit divisor
// and a 2-bit select, so the out-of-range select 3 can be exercised.
// Expected bit vectors are written {ch1, ch0}.
// The sync sequence is exercised only when CLKDIV_SYNC_EN is defined.
module tb_clk_tick_divider;

    logic       clk;
    logic       rst;
    logic [1:0] ch_en;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_div;
    logic [1:0] tick;
    logic [1:0] div_clk;
`ifdef CLKDIV_SYNC_EN
    logic       sync_in;
`endif

    int numCompared;
    int numMismatched;

    typedef struct {
        logic [1:0] en;
        logic       we;
        logic [1:0] wc;
        logic [7:0] wd;
        logic [1:0] expTick;
        logic [1:0] expDiv;
    } vec_t;

    vec_t vecs[35];

    clk_tick_divider #(
        .NUM_CH      (2),
        .CNT_W       (8),
        .CH_W        (2),
        .DEFAULT_DIV (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ch_en   (ch_en),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .tick    (tick),
        .div_clk (div_clk)
`ifdef CLKDIV_SYNC_EN
        ,
        .sync_in (sync_in)
`endif
    );

    // Free-running system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, then sample 1 time unit after the active edge.
    task automatic applyStimulus(input logic [1:0] en, input logic we,
                                 input logic [1:0] wc, input logic [7:0] wd);
        ch_en  = en;
        wr_en  = we;
        wr_ch  = wc;
        wr_div = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] expTick,
                               input logic [1:0] expDiv);
        numCompared++;
        if (tick !== expTick) begin
            numMismatched++;
            $display("[TB] FAIL %s tick: got %b want %b", name, tick, expTick);
        end
        numCompared++;
        if (div_clk !== expDiv) begin
            numMismatched++;
            $display("[TB] FAIL %s div_clk: got %b want %b", name, div_clk, expDiv);
        end
    endtask

    // Main test sequence: table-driven vectors first, then the reset and sync corner cases.
    initial begin
        numCompared   = 0;
        numMismatched = 0;
`ifdef CLKDIV_SYNC_EN
        sync_in = 1'b0;
`endif

        // Divisor 4 on both channels. Write ch1 <= 5 at cnt=1. Then write 0, an ignored
        // select 3, and 1. Freeze ch0 for 3 cycles while writing it 2. Then write 7, then 3.
        // The second write lands on the wrap, bypasses the shadow, and wins.
        vecs[0]  = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00};
        vecs[1]  = '{2'b11, 1'b1, 2'd1, 8'd5, 2'b00, 2'b11};
        vecs[2]  = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b00, 2'b11};
        vecs[3]  = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b11, 2'b00};
        vecs[4]  = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00};
        vecs[5]  = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b00, 2'b11};
        vecs[6]  = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b00, 2'b11};
        vecs[7]  = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b01, 2'b10};
        vecs[8]  = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b10, 2'b00};
        vecs[9]  = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b00, 2'b01};
        vecs[10] = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b00, 2'b11};
        vecs[11] = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b01, 2'b10};
        vecs[12] = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b00, 2'b10};
        vecs[13] = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b10, 2'b01};
        vecs[14] = '{2'b11, 1'b1, 2'd1, 8'd0, 2'b00, 2'b01};
        vecs[15] = '{2'b11, 1'b1, 2'd3, 8'd9, 2'b01, 2'b10};
        vecs[16] = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b00, 2'b10};
        vecs[17] = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b00, 2'b11};
        vecs[18] = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b10, 2'b01};
        vecs[19] = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b11, 2'b10};
        vecs[20] = '{2'b11, 1'b1, 2'd1, 8'd1, 2'b10, 2'b10};
        vecs[21] = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b10, 2'b11};
        vecs[22] = '{2'b10, 1'b0, 2'd0, 8'd0, 2'b10, 2'b11};
        vecs[23] = '{2'b10, 1'b1, 2'd0, 8'd2, 2'b10, 2'b11};
        vecs[24] = '{2'b10, 1'b0, 2'd0, 8'd0, 2'b10, 2'b11};
        vecs[25] = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b10, 2'b11};
        vecs[26] = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b11, 2'b10};
        vecs[27] = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b10, 2'b11};
        vecs[28] = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b11, 2'b10};
        vecs[29] = '{2'b11, 1'b1, 2'd0, 8'd7, 2'b10, 2'b11};
        vecs[30] = '{2'b11, 1'b1, 2'd0, 8'd3, 2'b11, 2'b10};
        vecs[31] = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b10, 2'b11};
        vecs[32] = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b10, 2'b11};
        vecs[33] = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b11, 2'b10};
        vecs[34] = '{2'b11, 1'b0, 2'd0, 8'd0, 2'b10, 2'b11};

        rst = 1'b1;
        applyStimulus(2'b11, 1'b0, 2'd0, 8'd0);
        applyStimulus(2'b11, 1'b0, 2'd0, 8'd0);
        checkOutput("reset", 2'b00, 2'b00);
        rst = 1'b0;

        for (int i = 0; i < 35; i++) begin
            applyStimulus(vecs[i].en, vecs[i].we, vecs[i].wc, vecs[i].wd);
            checkOutput($sformatf("vec%0d", i), vecs[i].expTick, vecs[i].expDiv);
        end

        // Reset at cnt=2 with 7 pending on ch0. The pending value must be lost,
        // so both channels return to divisor 4.
        applyStimulus(2'b11, 1'b1, 2'd0, 8'd7);
        checkOutput("pre_rst", 2'b10, 2'b11);
        rst = 1'b1;
        applyStimulus(2'b11, 1'b0, 2'd0, 8'd0);
        checkOutput("mid_rst", 2'b00, 2'b00);
        rst = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            logic t;
            logic d;
            t = (n % 4 == 0);
            d = (n % 4 == 2) || (n % 4 == 3);
            applyStimulus(2'b11, 1'b0, 2'd0, 8'd0);
            checkOutput($sformatf("post_rst%0d", n), {t, t}, {d, d});
        end

`ifdef CLKDIV_SYNC_EN
        // Move ch1 out of phase with 6 pending, then sync. The divisors 4 and 6
        // should then tick together every 12 cycles.
        applyStimulus(2'b11, 1'b1, 2'd1, 8'd6);
        applyStimulus(2'b01, 1'b0, 2'd0, 8'd0);
        sync_in = 1'b1;
        applyStimulus(2'b11, 1'b0, 2'd0, 8'd0);
        checkOutput("sync_clear", 2'b00, 2'b00);
        sync_in = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            logic [1:0] t;
            logic [1:0] d;
            t[0] = (k % 4 == 0);
            t[1] = (k % 6 == 0);
            d[0] = (k % 4 == 2) || (k % 4 == 3);
            d[1] = (k % 6 >= 3);
            applyStimulus(2'b11, 1'b0, 2'd0, 8'd0);
            checkOutput($sformatf("sync%0d", k), t, d);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
